// File: rtl/hud_pkg.sv
// hud_pkg: constants and types shared by the HUD overlay blocks.
//   SPRITE_SIZE  - heart sprite edge length in pixels
//   TRANSPARENT  - RGB222 colour key meaning "no pixel"
//   GREY_RGB     - per-channel colour used for lost hearts
//   draw_mode_t  - how a slot pixel is to be drawn (NONE, FULL, GREY)
//   hud_state_t  - blink controller state (IDLE, BLINK)
package hud_pkg;

  localparam int         SPRITE_SIZE = 16;
  localparam logic [5:0] TRANSPARENT = 6'b000000;
  localparam logic [2:0] GREY_RGB    = 3'b010;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    FULL = 2'd1,
    GREY = 2'd2
  } draw_mode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BLINK = 1'b1
  } hud_state_t;

endpackage

// File: rtl/heart_sprite_rom.sv
// heart_sprite_rom: 16x16 RGB222 heart sprite with a one-clock read.
//   clk         in  - pixel clock
//   sprite_x    in  - texel column 0..15
//   sprite_y    in  - texel row 0..15
//   pixel_data  out - registered RGB222 texel, 6'b000000 = transparent
module heart_sprite_rom (
  input  logic       clk,
  input  logic [3:0] sprite_x,
  input  logic [3:0] sprite_y,
  output logic [5:0] pixel_data
);

  // Shape mask: bit 15 is column 0. Every opaque texel is solid red.
  localparam logic [5:0] HEART_RGB = 6'b110000;

  logic [15:0] w_row;
  logic        w_opaque;

  always_comb begin
    w_row = 16'h0000;
    case (sprite_y)
      4'd1:    w_row = 16'h3838;
      4'd2:    w_row = 16'h7C7C;
      4'd3:    w_row = 16'hFEFE;
      4'd4:    w_row = 16'hFFFE;
      4'd5:    w_row = 16'hFFFE;
      4'd6:    w_row = 16'hFFFE;
      4'd7:    w_row = 16'h7FFC;
      4'd8:    w_row = 16'h3FF8;
      4'd9:    w_row = 16'h1FF0;
      4'd10:   w_row = 16'h0FE0;
      4'd11:   w_row = 16'h07C0;
      4'd12:   w_row = 16'h0380;
      4'd13:   w_row = 16'h0100;
      default: w_row = 16'h0000;
    endcase
  end

  assign w_opaque = w_row[4'd15 - sprite_x];

  always_ff @(posedge clk) begin
    pixel_data <= w_opaque ? HEART_RGB : 6'b000000;
  end

endmodule

// File: rtl/lives_hud.sv
// lives_hud: row of heart sprites showing the remaining lives, with lost
// hearts drawn grey (or hidden) and newly lost hearts blinking.
//   clk          in  - pixel clock
//   rst_n        in  - asynchronous active-low reset
//   lives        in  - life count, sampled only on frame_start
//   frame_start  in  - one-cycle pulse at the start of vertical blank
//   h_count      in  - current column
//   v_count      in  - current row
//   pix_valid    out - opaque HUD pixel present, 2 clocks after h/v_count
//   vga_r/g/b    out - pixel colour, 0 whenever pix_valid is 0
module lives_hud
  import hud_pkg::*;
#(
  parameter int MAX_LIVES    = 5,
  parameter int LIVES_W      = 3,
  parameter int X_START      = 160,
  parameter int Y_POS        = 460,
  parameter int PITCH_LOG2   = 5,
  parameter int BLINK_FRAMES = 60,
  parameter int BLINK_PERIOD = 8,
  parameter bit SHOW_EMPTY   = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LIVES_W-1:0] lives,
  input  logic               frame_start,
  input  logic [9:0]         h_count,
  input  logic [8:0]         v_count,
  output logic               pix_valid,
  output logic [2:0]         vga_r,
  output logic [2:0]         vga_g,
  output logic [2:0]         vga_b
);

  localparam int FC_W = $clog2(BLINK_FRAMES + 1);
  localparam int PC_W = $clog2(BLINK_PERIOD + 1);

  localparam logic [FC_W-1:0]    FC_LOAD    = FC_W'(BLINK_FRAMES - 1);
  localparam logic [PC_W-1:0]    PC_LAST    = PC_W'(BLINK_PERIOD - 1);
  localparam logic [LIVES_W-1:0] MAX_L      = LIVES_W'(MAX_LIVES);
  localparam logic [9:0]         X0         = 10'(X_START);
  localparam logic [9:0]         Y0         = 10'(Y_POS);
  localparam logic [9:0]         SPR        = 10'(SPRITE_SIZE);
  localparam logic [9:0]         N_SLOTS    = 10'(MAX_LIVES);
  localparam logic [9:0]         PITCH_MASK = 10'((1 << PITCH_LOG2) - 1);

  if ((MAX_LIVES < 1) || (MAX_LIVES > 7) || (PITCH_LOG2 < 4) ||
      (MAX_LIVES * (1 << PITCH_LOG2) + X_START > 640) ||
      (Y_POS + SPRITE_SIZE > 480) || (MAX_LIVES >= (1 << LIVES_W))) begin : g_bad_params
    $error("lives_hud: parameters place the heart row outside 640x480 or out of range");
  end

  // ---------------- blink controller (frame_start domain) ----------------
  hud_state_t         r_state;
  logic [LIVES_W-1:0] r_lives_q;
  logic [LIVES_W-1:0] r_blink_lo;
  logic [LIVES_W-1:0] r_blink_hi;
  logic [FC_W-1:0]    r_frame_cnt;
  logic [PC_W-1:0]    r_per_cnt;
  logic               r_phase;
  logic [LIVES_W-1:0] w_new;

  assign w_new = (lives > MAX_L) ? MAX_L : lives;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_lives_q   <= '0;
      r_blink_lo  <= '0;
      r_blink_hi  <= '0;
      r_frame_cnt <= '0;
      r_per_cnt   <= '0;
      r_phase     <= 1'b0;
    end else if (frame_start) begin
      r_lives_q <= w_new;
      if (w_new < r_lives_q) begin
        // A loss starts or restarts the blink. The upper bound is only set
        // from IDLE so a second loss widens the blinking range downward.
        r_state     <= BLINK;
        r_blink_lo  <= w_new;
        if (r_state == IDLE) r_blink_hi <= r_lives_q - 1'b1;
        r_frame_cnt <= FC_LOAD;
        r_per_cnt   <= '0;
        r_phase     <= 1'b0;
      end else if (r_state == BLINK) begin
        if (w_new > r_lives_q) begin
          r_state <= IDLE;
        end else if (r_frame_cnt == '0) begin
          r_state <= IDLE;
        end else begin
          r_frame_cnt <= r_frame_cnt - 1'b1;
          if (r_per_cnt == PC_LAST) begin
            r_per_cnt <= '0;
            r_phase   <= ~r_phase;
          end else begin
            r_per_cnt <= r_per_cnt + 1'b1;
          end
        end
      end
    end
  end

  // ---------------- stage 0: slot decode ----------------
  logic [9:0] w_dx;
  logic [9:0] w_dy;
  logic [9:0] w_slot;
  logic       w_in_win;
  logic       w_full;
  logic       w_blinking;
  draw_mode_t w_mode;

  // Subtractions wrap when left of / above the row; the >= tests reject that.
  assign w_dx   = h_count - X0;
  assign w_dy   = {1'b0, v_count} - Y0;
  assign w_slot = w_dx >> PITCH_LOG2;

  assign w_in_win = (h_count >= X0) && (w_slot < N_SLOTS) &&
                    ((w_dx & PITCH_MASK) < SPR) &&
                    ({1'b0, v_count} >= Y0) && (w_dy < SPR);

  assign w_full     = w_slot < 10'(r_lives_q);
  assign w_blinking = (r_state == BLINK) &&
                      (w_slot >= 10'(r_blink_lo)) && (w_slot <= 10'(r_blink_hi));

  always_comb begin
    w_mode = NONE;
    if (!w_in_win)       w_mode = NONE;
    else if (w_full)     w_mode = FULL;
    else if (w_blinking) w_mode = r_phase ? FULL : NONE;
    else                 w_mode = SHOW_EMPTY ? GREY : NONE;
  end

  // ---------------- stage 1: ROM read + draw mode ----------------
  logic [5:0] w_texel;
  draw_mode_t r_mode_s1;

  heart_sprite_rom u_rom (
    .clk        (clk),
    .sprite_x   (w_dx[3:0]),
    .sprite_y   (w_dy[3:0]),
    .pixel_data (w_texel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mode_s1 <= NONE;
    else        r_mode_s1 <= w_mode;
  end

  // ---------------- stage 2: colour out ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      vga_r     <= 3'b000;
      vga_g     <= 3'b000;
      vga_b     <= 3'b000;
    end else if ((r_mode_s1 == NONE) || (w_texel == TRANSPARENT)) begin
      pix_valid <= 1'b0;
      vga_r     <= 3'b000;
      vga_g     <= 3'b000;
      vga_b     <= 3'b000;
    end else if (r_mode_s1 == GREY) begin
      pix_valid <= 1'b1;
      vga_r     <= GREY_RGB;
      vga_g     <= GREY_RGB;
      vga_b     <= GREY_RGB;
    end else begin
      pix_valid <= 1'b1;
      vga_r     <= {w_texel[5:4], 1'b0};
      vga_g     <= {w_texel[3:2], 1'b0};
      vga_b     <= {w_texel[1:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_lives_hud.sv
module tb_lives_hud;

  // Observed pixel is packed as {pix_valid, r, g, b}.
  localparam logic [9:0] PX_NONE = 10'b0_000_000_000;
  localparam logic [9:0] PX_FULL = 10'b1_110_000_000;  // red heart texel
  localparam logic [9:0] PX_GREY = 10'b1_010_010_010;

  // Sample texel (4,5) lies inside the heart shape; (0,0) is transparent.
  localparam int HX  = 4;
  localparam int HY  = 465;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] lives = 3'd0;
  logic       frame_start = 1'b0;
  logic [9:0] h_count = 10'd0;
  logic [8:0] v_count = 9'd0;
  logic       pix_valid;
  logic [2:0] vga_r, vga_g, vga_b;

  always #5 clk = ~clk;

  lives_hud dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lives       (lives),
    .frame_start (frame_start),
    .h_count     (h_count),
    .v_count     (v_count),
    .pix_valid   (pix_valid),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  function automatic logic [9:0] obs_px();
    return {pix_valid, vga_r, vga_g, vga_b};
  endfunction

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_frame(input logic [2:0] lv);
    @(negedge clk);
    lives       = lv;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic frames(input int n, input logic [2:0] lv);
    for (int k = 0; k < n; k++) pulse_frame(lv);
  endtask

  // Hold a position and check the output two clocks later.
  task automatic check_pix(input string tag, input int h, input int v, input logic [9:0] exp_v);
    @(negedge clk);
    h_count = 10'(h);
    v_count = 9'(v);
    @(posedge clk);
    @(posedge clk);
    #1;
    check(tag, obs_px(), exp_v);
  endtask

  task automatic check_slot(input string tag, input int slot, input logic [9:0] exp_v);
    check_pix(tag, 160 + 32 * slot + HX, HY, exp_v);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #1 check("reset_out", obs_px(), PX_NONE);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Lives 3, static
    pulse_frame(3'd3);
    check_slot("s3_slot0", 0, PX_FULL);
    check_slot("s3_slot2", 2, PX_FULL);
    check_slot("s3_slot3", 3, PX_GREY);
    check_slot("s3_slot4", 4, PX_GREY);
    check_pix("transparent_texel", 160, 460, PX_NONE);
    check_pix("gap_pixel", 160 + 16 + 3, HY, PX_NONE);
    check_pix("left_of_row", 159, HY, PX_NONE);
    check_pix("slot5_absent", 160 + 5 * 32 + HX, HY, PX_NONE);
    check_pix("below_row", 160 + HX, 476, PX_NONE);

    // Exact two-clock latency
    @(negedge clk);
    h_count = 10'd100;
    v_count = 9'(HY);
    repeat (3) @(posedge clk);
    @(negedge clk);
    h_count = 10'(160 + HX);
    @(posedge clk); #1;
    check("lat_edge1", obs_px(), PX_NONE);
    @(negedge clk);
    h_count = 10'd100;
    @(posedge clk); #1;
    check("lat_edge2", obs_px(), PX_FULL);
    @(posedge clk); #1;
    check("lat_edge3", obs_px(), PX_NONE);

    // Loss 3 -> 2
    pulse_frame(3'd2);
    check_slot("loss_f0_slot2", 2, PX_NONE);
    check_slot("loss_f0_slot1", 1, PX_FULL);
    check_slot("loss_f0_slot3", 3, PX_GREY);
    frames(7, 3'd2);
    check_slot("loss_f7_slot2", 2, PX_NONE);
    pulse_frame(3'd2);
    check_slot("loss_f8_slot2", 2, PX_FULL);
    frames(7, 3'd2);
    check_slot("loss_f15_slot2", 2, PX_FULL);
    pulse_frame(3'd2);
    check_slot("loss_f16_slot2", 2, PX_NONE);
    frames(43, 3'd2);
    check_slot("loss_f59_slot2", 2, PX_FULL);
    pulse_frame(3'd2);
    check_slot("loss_f60_slot2", 2, PX_GREY);

    // Double loss mid-blink
    pulse_frame(3'd3);
    check_slot("dbl_gain_idle", 2, PX_FULL);
    pulse_frame(3'd2);
    frames(19, 3'd2);
    check_slot("dbl_f19_slot2", 2, PX_NONE);
    check_slot("dbl_f19_slot0", 0, PX_FULL);
    pulse_frame(3'd0);
    check_slot("dbl_r0_slot0", 0, PX_NONE);
    check_slot("dbl_r0_slot2", 2, PX_NONE);
    check_slot("dbl_r0_slot3", 3, PX_GREY);
    frames(7, 3'd0);
    check_slot("dbl_r7_slot1", 1, PX_NONE);
    pulse_frame(3'd0);
    check_slot("dbl_r8_slot0", 0, PX_FULL);
    check_slot("dbl_r8_slot2", 2, PX_FULL);
    frames(51, 3'd0);
    check_slot("dbl_r59_slot2", 2, PX_FULL);
    pulse_frame(3'd0);
    check_slot("dbl_r60_slot0", 0, PX_GREY);

    // Gain during blink
    pulse_frame(3'd3);
    pulse_frame(3'd2);
    check_slot("gain_f0_slot2", 2, PX_NONE);
    frames(9, 3'd2);
    pulse_frame(3'd3);
    check_slot("gain_f10_slot2", 2, PX_FULL);
    check_slot("gain_f10_slot0", 0, PX_FULL);
    check_slot("gain_f10_slot3", 3, PX_GREY);

    // Clamp and mid-frame change
    pulse_frame(3'd7);
    check_slot("clamp_slot4", 4, PX_FULL);
    check_pix("clamp_slot5", 160 + 5 * 32 + HX, HY, PX_NONE);
    @(negedge clk);
    lives = 3'd1;
    check_slot("midframe_slot4", 4, PX_FULL);
    pulse_frame(3'd1);
    check_slot("loss5to1_slot0", 0, PX_FULL);
    check_slot("loss5to1_slot1", 1, PX_NONE);
    check_slot("loss5to1_slot4", 4, PX_NONE);

    // Async reset mid-line
    check_slot("pre_reset_slot0", 0, PX_FULL);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_reset_out", obs_px(), PX_NONE);
    @(negedge clk);
    rst_n = 1'b1;
    check_slot("post_reset_slot0", 0, PX_GREY);
    pulse_frame(3'd3);
    check_slot("post_reset_load_slot2", 2, PX_FULL);
    check_slot("post_reset_load_slot3", 3, PX_GREY);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lives_hud.md
# lives_hud

Parametrised heart-row HUD overlay for the VGA pipeline, the successor to the fixed three-heart display. Draws up to `MAX_LIVES` heart sprites in a row, greys out lost hearts when `SHOW_EMPTY` is set, and blinks newly lost hearts for a fixed number of frames. The output is registered, with a fixed 2-cycle latency from `h_count`/`v_count`. It also produces a `pix_valid` flag, which the top-level colour mux uses to overlay this block on the playfield.

## Interface
- `MAX_LIVES`, 5: number of heart slots, 1..7.
- `LIVES_W`, 3: width of `lives`.
- `X_START`, 160: left pixel of slot 0.
- `Y_POS`, 460: top row of the hearts.
- `PITCH_LOG2`, 5: slot pitch is 2^PITCH_LOG2 pixels (sprite 16 plus gap). Must be ≥4.
- `BLINK_FRAMES`, 60: total frames a lost heart blinks.
- `BLINK_PERIOD`, 8: frames per blink half-phase.
- `SHOW_EMPTY`, 1: when 1, lost hearts are drawn grey (3'b010 on r, g and b); when 0, lost hearts are not drawn.

Ports:
- `clk` in 1: pixel clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `lives` in LIVES_W: current life count. Sampled only at `frame_start`.
- `frame_start` in 1: one-cycle pulse at the start of vertical blank.
- `h_count` in 10: current column.
- `v_count` in 9: current row.
- `pix_valid` out 1: opaque HUD pixel present (registered).
- `vga_r`, `vga_g`, `vga_b` out 3 each: pixel colour (registered).

## Operation
- Slot geometry: slot `i` covers x in [X_START + i·2^PITCH_LOG2, +16) and y in [Y_POS, Y_POS+16). Slot index is (h_count − X_START) >> PITCH_LOG2. It is valid only when h_count ≥ X_START, the index is < MAX_LIVES, and the low PITCH_LOG2 bits are < 16. All arithmetic is done at 10 bits.
- Sprite pixel: 6-bit RGB222 from the ROM. The value 6'b000000 is transparent. Output colour is {2-bit, 1'b0} per channel.
- Live count:
  - `lives_q` is updated only on `frame_start`, so a count change never tears a frame.
  - Inputs above MAX_LIVES are clamped to MAX_LIVES.
- Heart state for slot `i`:
  - **Full** if i < lives_q.
  - **Blinking** if the FSM is in BLINK and blink_lo ≤ i ≤ blink_hi. Drawn as full while `phase`=1 and hidden while `phase`=0.
  - **Empty** otherwise. Drawn grey or hidden, per SHOW_EMPTY.
- FSM states are IDLE and BLINK. All transitions are evaluated only on `frame_start`, using new = clamp(lives).
  - **IDLE, new < lives_q:** go to BLINK. Set blink_lo = new, blink_hi = lives_q − 1, frame_cnt = BLINK_FRAMES − 1, per_cnt = 0, phase = 0.
  - **BLINK, new < lives_q:** restart the blink. Set blink_lo = new, keep blink_hi, reload frame_cnt, per_cnt = 0, phase = 0.
  - **BLINK, new > lives_q:** go to IDLE. A life gain cancels the blink.
  - **BLINK, no change:**
    - If frame_cnt = 0, go to IDLE.
    - Otherwise decrement frame_cnt and increment per_cnt.
    - When per_cnt reaches BLINK_PERIOD−1, per_cnt wraps to 0 and phase toggles.
  - In all cases, `lives_q` is set to new on `frame_start`.
- Reset values: `lives_q`=0, IDLE, all counters 0, `phase`=0, `pix_valid`=0, all colour outputs 0. The first `frame_start` after reset loads `lives` and never triggers a blink.

## Timing
- Stage 0, combinational: slot decode, sprite x/y computation, in-window flag.
- Stage 1, registered: sprite coordinates to the ROM; draw mode {full, grey, none} registered alongside.
- Stage 2, registered: ROM data (1-cycle read) and draw mode are combined into `vga_*` and `pix_valid`.
- Total latency is 2 clocks from `h_count`. The top level delays its own pipeline by 2 to align.
- Outside the window, or on a transparent texel: `pix_valid`=0 and colour 0.
- The FSM updates in the same cycle as `frame_start`. The new state applies to the first visible line of the next frame.
- If `rst_n` is asserted mid-frame, outputs are 0 immediately, with no waiting for a clock.

## Structure
- Shared package `hud_pkg` holds:
  - sprite size 16 and the transparent key 6'b000000;
  - grey colour 3'b010;
  - the draw-mode enum (NONE, FULL, GREY);
  - the FSM state enum (IDLE, BLINK).
- One sub-module, `heart_sprite_rom`: 16×16×6-bit synchronous ROM with inputs `clk`, `sprite_x[3:0]`, `sprite_y[3:0]` and output `pixel_data[5:0]`.
- Elaboration check: MAX_LIVES·2^PITCH_LOG2 + X_START ≤ 640, and Y_POS+16 ≤ 480.

## Test plan
- **Lives 3, static:** after the first `frame_start`, sweep a frame. Expect opaque pixels only in slots 0–2. Slots 3–4 are grey (SHOW_EMPTY=1). `pix_valid` lags the window by exactly 2 clocks.
- **Loss 3→2:** at `frame_start`, slot 2 hidden for frames 0–7, full for 8–15, and so on. Back to IDLE after 60 frames; slot 2 then grey.
- **Double loss mid-blink:** 3→2, then 2→0 at frame 20. blink_lo=0, blink_hi=2, counter restarted. All three blink for 60 frames from frame 20.
- **Gain during blink:** 2→3 at frame 10. Immediate IDLE; slots 0–2 full on the next frame.
- **Clamp and mid-frame change:** `lives`=7 gives 5 full hearts. A mid-frame change on `lives` without `frame_start` gives no change in the current frame.
- **Async reset:** assert `rst_n`=0 mid-line. Outputs are 0 within the same cycle. After release, the first `frame_start` loads with no blink.
